// File: rtl/pixel_unpacker_pkg.sv
// Shared types and constants for the pixel unpacker.
// The FSM state type, byte geometry and the default frame size live here.
package pixel_unpacker_pkg;

  localparam int BYTES_PER_WORD     = 4;
  localparam int DEFAULT_WORD_COUNT = 32'h41EC;
  localparam int WORD_IDX_W         = 17;
  localparam int BYTE_IDX_W         = 2;
  localparam int PIX_IDX_W          = WORD_IDX_W + BYTE_IDX_W;

  // IDLE waits for start, READ strobes memory, WAIT captures the word,
  // EMIT writes four pixels, DONE pulses the end-of-frame flag.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WAIT = 3'd2,
    ST_EMIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Framebuffer pixel index of byte b inside word w.
  function automatic logic [PIX_IDX_W-1:0] make_pix(
    input logic [WORD_IDX_W-1:0] w,
    input logic [BYTE_IDX_W-1:0] b
  );
    return {w, b};
  endfunction

endpackage

// File: rtl/pixel_unpacker_if.sv
// Memory-read and framebuffer-write bus of the pixel unpacker.
// Memory side: mem_read is a one-cycle strobe with memory_address; the slave
// presents data_memory during the following cycle (no backpressure).
// Framebuffer side: writeData qualifies vga_datain/pix_address, one pixel per
// cycle; the framebuffer always accepts (no ready).
interface pixel_unpacker_if #(
  parameter int PIX_W = 19
);
  logic [16:0]      memory_address;
  logic             mem_read;
  logic [31:0]      data_memory;
  logic [7:0]       vga_datain;
  logic [PIX_W-1:0] pix_address;
  logic             writeData;

  modport master (
    output memory_address,
    output mem_read,
    input  data_memory,
    output vga_datain,
    output pix_address,
    output writeData
  );

  modport slave (
    input  memory_address,
    input  mem_read,
    output data_memory,
    input  vga_datain,
    input  pix_address,
    input  writeData
  );
endinterface

// File: rtl/pixel_byte_select.sv
// Combinational 32-to-8 byte mux.
// Default order is LSB first (index 0 -> bits [7:0]); defining
// PIXEL_UNPACKER_MSB_FIRST_EN makes index 0 select bits [31:24].
module pixel_byte_select
  import pixel_unpacker_pkg::*;
(
  input  logic [31:0]           i_word,
  input  logic [BYTE_IDX_W-1:0] i_idx,
  output logic [7:0]            o_byte
);

  // Pick one byte of the word by position.
  always_comb begin
    o_byte = 8'h00;
    case (i_idx)
`ifdef PIXEL_UNPACKER_MSB_FIRST_EN
      2'd0: o_byte = i_word[31:24];
      2'd1: o_byte = i_word[23:16];
      2'd2: o_byte = i_word[15:8];
      2'd3: o_byte = i_word[7:0];
`else
      2'd0: o_byte = i_word[7:0];
      2'd1: o_byte = i_word[15:8];
      2'd2: o_byte = i_word[23:16];
      2'd3: o_byte = i_word[31:24];
`endif
      default: o_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/pixel_unpacker.sv
// Pixel unpacker: reads WORD_COUNT 32-bit words and writes each as four
// 8-bit pixels to a VGA framebuffer, one pixel per cycle.
// Optional macro PIXEL_UNPACKER_MSB_FIRST_EN selects MSB-first byte order.
// All strobes and pixel outputs are registered from next-state values so
// they change only on the clock edge.
module pixel_unpacker
  import pixel_unpacker_pkg::*;
#(
  parameter int WORD_COUNT = DEFAULT_WORD_COUNT,
  parameter int PIX_W      = 19
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output state_t           o_dbg_state,
  pixel_unpacker_if.master bus
);

  localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(WORD_COUNT - 1);
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  state_t                r_state;
  logic [WORD_IDX_W-1:0] r_word_idx;
  logic [BYTE_IDX_W-1:0] r_byte_idx;
  logic [31:0]           r_word;
  logic                  r_write;
  logic                  r_mem_read;
  logic                  r_done;
  logic [7:0]            r_vga;
  logic [PIX_IDX_W-1:0]  r_pix;

  state_t                w_state_nxt;
  logic [WORD_IDX_W-1:0] w_word_idx_nxt;
  logic [BYTE_IDX_W-1:0] w_byte_idx_nxt;
  logic [31:0]           w_word_nxt;
  logic                  w_write_nxt;
  logic                  w_mem_read_nxt;
  logic                  w_done_nxt;
  logic [7:0]            w_sel_byte;

  // The mux looks at the next word/byte so the registered pixel lines up
  // with the registered writeData on the same edge.
  pixel_byte_select u_byte_select (
    .i_word (w_word_nxt),
    .i_idx  (w_byte_idx_nxt),
    .o_byte (w_sel_byte)
  );

  // Next-state, counter and strobe decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_word_idx_nxt = r_word_idx;
    w_byte_idx_nxt = r_byte_idx;
    w_word_nxt     = r_word;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt    = ST_READ;
          w_word_idx_nxt = '0;
        end
      end
      ST_READ: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_state_nxt    = ST_EMIT;
        w_byte_idx_nxt = '0;
        w_word_nxt     = bus.data_memory;
      end
      ST_EMIT: begin
        // The 2-bit byte index wraps back to 0 after byte 3.
        w_byte_idx_nxt = r_byte_idx + 1'b1;
        if (r_byte_idx == LAST_BYTE) begin
          if (r_word_idx == LAST_WORD) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt    = ST_READ;
            w_word_idx_nxt = r_word_idx + 1'b1;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt    = ST_IDLE;
        w_word_idx_nxt = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_write_nxt    = (w_state_nxt == ST_EMIT);
    w_mem_read_nxt = (w_state_nxt == ST_READ);
    w_done_nxt     = (w_state_nxt == ST_DONE);
  end

  // State, counters, captured word and registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_word     <= '0;
      r_write    <= 1'b0;
      r_mem_read <= 1'b0;
      r_done     <= 1'b0;
      r_vga      <= '0;
      r_pix      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_word_idx <= w_word_idx_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_word     <= w_word_nxt;
      r_write    <= w_write_nxt;
      r_mem_read <= w_mem_read_nxt;
      r_done     <= w_done_nxt;
      // Pixel lines hold their last value outside EMIT.
      if (w_write_nxt) begin
        r_vga <= w_sel_byte;
        r_pix <= make_pix(w_word_idx_nxt, w_byte_idx_nxt);
      end
    end
  end

  assign bus.memory_address = r_word_idx;
  assign bus.mem_read       = r_mem_read;
  assign bus.writeData      = r_write;
  assign bus.vga_datain     = r_vga;
  assign bus.pix_address    = PIX_W'(r_pix);
  assign done               = r_done;
  assign busy               = (r_state != ST_IDLE);
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_pixel_unpacker.sv
// Self-checking bench for pixel_unpacker with WORD_COUNT=2.
// Honours PIXEL_UNPACKER_MSB_FIRST_EN for the expected byte order.
module tb_pixel_unpacker;
  import pixel_unpacker_pkg::*;

  localparam int WC = 2;
  localparam int PW = 19;

  logic   clock  = 1'b0;
  logic   resetn = 1'b0;
  logic   start  = 1'b0;
  logic   busy;
  logic   done;
  state_t dbg_state;

  int checks   = 0;
  int failures = 0;

  pixel_unpacker_if #(.PIX_W(PW)) bus ();

  pixel_unpacker #(.WORD_COUNT(WC), .PIX_W(PW)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .o_dbg_state (dbg_state),
    .bus         (bus)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- memory model: data valid only the cycle after mem_read
  logic [31:0] mem [0:WC-1];
  logic        rd_pend = 1'b0;
  logic [16:0] rd_addr = '0;
  logic [31:0] rdata   = '0;
  assign bus.data_memory = rdata;

  always @(negedge clock) begin
    if (rd_pend) rdata <= mem[rd_addr[0]];
    else         rdata <= $urandom;
    rd_pend <= bus.mem_read;
    rd_addr <= bus.memory_address;
  end

  // ---------------- monitor ----------------
  int          cyc = 0;
  logic [26:0] wr_q[$];
  int          wr_cyc[$];
  int          rd_cyc[$];
  logic [16:0] rd_adr_q[$];
  int          done_cyc[$];

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (bus.writeData) begin
      wr_q.push_back({bus.pix_address, bus.vga_datain});
      wr_cyc.push_back(cyc);
    end
    if (bus.mem_read) begin
      rd_cyc.push_back(cyc);
      rd_adr_q.push_back(bus.memory_address);
    end
    if (done) done_cyc.push_back(cyc);
  end

  // ---------------- reference model ----------------
  logic [26:0] exp_q[$];

  function automatic logic [7:0] ref_byte(input logic [31:0] w, input int b);
    int sh;
`ifdef PIXEL_UNPACKER_MSB_FIRST_EN
    sh = 8 * (3 - b);
`else
    sh = 8 * b;
`endif
    return 8'((w >> sh) & 32'hFF);
  endfunction

  function automatic void build_exp();
    exp_q.delete();
    for (int w = 0; w < WC; w++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back({19'(w * 4 + b), ref_byte(mem[w], b)});
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_logs();
    wr_q.delete();
    wr_cyc.delete();
    rd_cyc.delete();
    rd_adr_q.delete();
    done_cyc.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_dones(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cyc.size() >= n) break;
      tick();
    end
    if (done_cyc.size() >= n) ok = 1'b1;
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (wr_q.size() >= n) break;
      tick();
    end
    if (wr_q.size() >= n) ok = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    start  = 1'b0;
    tick();
    tick();
    checks++; if (bus.writeData !== 1'b0) begin failures++; $display("FAIL reset_writeData got=%b exp=0", bus.writeData); end
    checks++; if (bus.mem_read !== 1'b0) begin failures++; $display("FAIL reset_mem_read got=%b exp=0", bus.mem_read); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (bus.vga_datain !== 8'h00) begin failures++; $display("FAIL reset_vga got=%h exp=00", bus.vga_datain); end
    checks++; if (bus.pix_address !== '0) begin failures++; $display("FAIL reset_pix got=%h exp=0", bus.pix_address); end
    checks++; if (bus.memory_address !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus.memory_address); end
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    resetn = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_no_start_busy got=%b exp=0", busy); end
  endtask

  task automatic test_directed_frame();
    logic [7:0] tbl [8];
    bit ok;
`ifdef PIXEL_UNPACKER_MSB_FIRST_EN
    tbl = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44, 8'h33, 8'h22, 8'h11};
`else
    tbl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
`endif
    mem[0] = 32'hDDCCBBAA;
    mem[1] = 32'h44332211;
    clear_logs();
    pulse_start();
    wait_dones(1, 40, ok);
    repeat (4) tick();
    checks++; if (!ok) begin failures++; $display("FAIL directed_timeout got=no_done exp=done"); end
    checks++; if (wr_q.size() != 8) begin failures++; $display("FAIL directed_count got=%0d exp=8", wr_q.size()); end
    for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== {19'(i), tbl[i]}) begin
        failures++;
        $display("FAIL directed_write[%0d] got=(%0h,%0h) exp=(%0h,%0h)", i, wr_q[i][26:8], wr_q[i][7:0], i, tbl[i]);
      end
    end
    if (done_cyc.size() == 1 && rd_cyc.size() >= 1 && wr_cyc.size() == 8) begin
      checks++; if (done_cyc[0] - rd_cyc[0] + 1 != 13) begin failures++; $display("FAIL directed_cycles got=%0d exp=13", done_cyc[0] - rd_cyc[0] + 1); end
      checks++; if (done_cyc[0] != wr_cyc[7] + 1) begin failures++; $display("FAIL directed_done_timing got=%0d exp=%0d", done_cyc[0], wr_cyc[7] + 1); end
    end else begin
      checks++; failures++;
      $display("FAIL directed_events got=dones:%0d reads:%0d exp=dones:1 reads:2", done_cyc.size(), rd_cyc.size());
    end
    checks++; if (rd_adr_q.size() != 2) begin failures++; $display("FAIL directed_reads got=%0d exp=2", rd_adr_q.size()); end
    else begin
      checks++; if (rd_adr_q[0] !== 17'd0 || rd_adr_q[1] !== 17'd1) begin failures++; $display("FAIL directed_read_addr got=%0h,%0h exp=0,1", rd_adr_q[0], rd_adr_q[1]); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL directed_idle_after got=%b exp=0", busy); end
  endtask

  task automatic test_random_frames();
    bit ok;
    for (int f = 0; f < 4; f++) begin
      for (int w = 0; w < WC; w++) mem[w] = $urandom;
      build_exp();
      clear_logs();
      repeat ($urandom_range(0, 3)) tick();
      pulse_start();
      wait_dones(1, 40, ok);
      repeat (3) tick();
      checks++; if (!ok) begin failures++; $display("FAIL random_timeout frame=%0d got=no_done exp=done", f); end
      checks++; if (wr_q.size() != exp_q.size()) begin failures++; $display("FAIL random_count frame=%0d got=%0d exp=%0d", f, wr_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
        checks++;
        if (wr_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL random_write frame=%0d idx=%0d got=%0h exp=%0h", f, i, wr_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_restart_during_emit();
    bit ok;
    mem[0] = 32'hDDCCBBAA;
    mem[1] = 32'h44332211;
    build_exp();
    clear_logs();
    pulse_start();
    wait_writes(1, 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL restart_first_write got=none exp=write"); end
    pulse_start();
    wait_dones(1, 40, ok);
    repeat (15) tick();
    checks++; if (wr_q.size() != 8) begin failures++; $display("FAIL restart_count got=%0d exp=8", wr_q.size()); end
    checks++; if (done_cyc.size() != 1) begin failures++; $display("FAIL restart_dones got=%0d exp=1", done_cyc.size()); end
    checks++; if (rd_cyc.size() != 2) begin failures++; $display("FAIL restart_reads got=%0d exp=2", rd_cyc.size()); end
    if (done_cyc.size() >= 1 && rd_cyc.size() >= 1) begin
      checks++; if (done_cyc[0] - rd_cyc[0] + 1 != 13) begin failures++; $display("FAIL restart_cycles got=%0d exp=13", done_cyc[0] - rd_cyc[0] + 1); end
    end
    for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin failures++; $display("FAIL restart_write idx=%0d got=%0h exp=%0h", i, wr_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int n;
    mem[0] = 32'hDDCCBBAA;
    mem[1] = 32'h44332211;
    clear_logs();
    pulse_start();
    wait_writes(2, 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL midreset_two_writes got=%0d exp=2", wr_q.size()); end
    resetn = 1'b0;
    #1;
    checks++; if (bus.writeData !== 1'b0) begin failures++; $display("FAIL midreset_writeData got=%b exp=0", bus.writeData); end
    checks++; if (bus.vga_datain !== 8'h00) begin failures++; $display("FAIL midreset_vga got=%h exp=00", bus.vga_datain); end
    checks++; if (bus.pix_address !== '0) begin failures++; $display("FAIL midreset_pix got=%h exp=0", bus.pix_address); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    checks++; if (bus.mem_read !== 1'b0 || done !== 1'b0 || bus.memory_address !== '0) begin
      failures++; $display("FAIL midreset_other got=rd:%b done:%b addr:%0h exp=0,0,0", bus.mem_read, done, bus.memory_address);
    end
    n = wr_q.size();
    repeat (3) tick();
    resetn = 1'b1;
    repeat (8) tick();
    checks++; if (wr_q.size() != n || busy !== 1'b0) begin failures++; $display("FAIL midreset_abort got=writes:%0d busy:%b exp=writes:%0d busy:0", wr_q.size(), busy, n); end
    clear_logs();
    pulse_start();
    wait_writes(1, 20, ok);
    checks++;
    if (!ok || wr_q[0] !== {19'd0, ref_byte(mem[0], 0)}) begin
      failures++;
      $display("FAIL midreset_restart got=%0h exp=%0h", ok ? wr_q[0] : 27'h0, {19'd0, ref_byte(mem[0], 0)});
    end
    wait_dones(1, 40, ok);
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int w = 0; w < WC; w++) mem[w] = $urandom;
    clear_logs();
    start = 1'b1;
    wait_dones(2, 60, ok);
    start = 1'b0;
    repeat (20) tick();
    checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout got=dones:%0d exp=2", done_cyc.size()); end
    checks++; if (done_cyc.size() != 2) begin failures++; $display("FAIL b2b_dones got=%0d exp=2", done_cyc.size()); end
    checks++; if (wr_q.size() != 16) begin failures++; $display("FAIL b2b_writes got=%0d exp=16", wr_q.size()); end
    checks++;
    if (rd_adr_q.size() != 4) begin
      failures++; $display("FAIL b2b_reads got=%0d exp=4", rd_adr_q.size());
    end else if (rd_adr_q[0] !== 17'd0 || rd_adr_q[1] !== 17'd1 || rd_adr_q[2] !== 17'd0 || rd_adr_q[3] !== 17'd1) begin
      failures++; $display("FAIL b2b_addr_seq got=%0h,%0h,%0h,%0h exp=0,1,0,1", rd_adr_q[0], rd_adr_q[1], rd_adr_q[2], rd_adr_q[3]);
    end
    if (rd_cyc.size() >= 3 && done_cyc.size() >= 1) begin
      checks++; if (rd_cyc[2] != done_cyc[0] + 2) begin failures++; $display("FAIL b2b_idle_gap got=%0d exp=%0d", rd_cyc[2], done_cyc[0] + 2); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_stops got=%b exp=0", busy); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed_frame();
    test_random_frames();
    test_restart_during_emit();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
